// File: rtl/control_unit.sv
// ---------------------------------------------------------------------------
// control_unit
//
// Microcoded sequencer for the 8-bit CPU. A six-state one-hot ring counter
// steps through T1..T6. T1-T3 fetch the instruction. T4-T6 execute the opcode
// held in the instruction register. Every strobe is combinational from the
// registered ring state, the sticky halt flag and ir_ins, and lasts one cycle.
//
// Optional feature: define CU_JMP_EN to decode opcode 0011 as JMP
// (T4: ir_out + pc_load). When CU_JMP_EN is undefined, 0011 is a NOP and
// pc_load is held at 0. The port exists in both builds.
//
// Ports:
//   clk      in   1  system clock, rising edge
//   rst      in   1  synchronous, active-high reset
//   ir_ins   in   4  opcode from the instruction register (used in T4-T6)
//   pc_inc   out  1  program counter increment
//   pc_out   out  1  program counter drives the bus
//   pc_load  out  1  program counter loads from the bus
//   mar_in   out  1  MAR loads from the bus
//   ram_out  out  1  RAM drives the bus
//   ir_in    out  1  instruction register loads from the bus
//   ir_out   out  1  instruction register drives the address nibble
//   acc_in   out  1  accumulator loads
//   acc_out  out  1  accumulator drives the bus
//   b_in     out  1  B register loads
//   alu_sub  out  1  ALU subtract select (1 = A-B)
//   alu_out  out  1  ALU drives the bus
//   out_in   out  1  output register loads
//   halt     out  1  CPU halted (sticky until reset)
//   t_ring   out  6  one-hot ring state, bit0 = T1 ... bit5 = T6
// ---------------------------------------------------------------------------
module control_unit (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] ir_ins,
    output logic       pc_inc,
    output logic       pc_out,
    output logic       pc_load,
    output logic       mar_in,
    output logic       ram_out,
    output logic       ir_in,
    output logic       ir_out,
    output logic       acc_in,
    output logic       acc_out,
    output logic       b_in,
    output logic       alu_sub,
    output logic       alu_out,
    output logic       out_in,
    output logic       halt,
    output logic [5:0] t_ring
);

    localparam int T1 = 0;
    localparam int T2 = 1;
    localparam int T3 = 2;
    localparam int T4 = 3;
    localparam int T5 = 4;
    localparam int T6 = 5;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_JMP = 4'b0011;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

`ifdef CU_JMP_EN
    localparam bit JMP_EN = 1'b1;
`else
    localparam bit JMP_EN = 1'b0;
`endif

    logic [5:0] ring_q;
    logic [5:0] ring_d;
    logic       halt_q;
    logic       halt_d;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            ring_q <= 6'b000001;
            halt_q <= 1'b0;
        end else begin
            ring_q <= ring_d;
            halt_q <= halt_d;
        end
    end

    // Next-state logic. HLT freezes the ring at T4 on the same edge that
    // sets halt, so the ring never leaves T4 once a halt is taken.
    always_comb begin
        halt_d = halt_q;
        ring_d = {ring_q[4:0], ring_q[5]};
        if (halt_q) begin
            ring_d = ring_q;
        end else if (ring_q[T4] && (ir_ins == OP_HLT)) begin
            halt_d = 1'b1;
            ring_d = ring_q;
        end
    end

    // Output decode. Reset is included here so that the cycle in which rst
    // is sampled shows no partial strobes from the state being abandoned.
    always_comb begin
        pc_inc  = 1'b0;
        pc_out  = 1'b0;
        pc_load = 1'b0;
        mar_in  = 1'b0;
        ram_out = 1'b0;
        ir_in   = 1'b0;
        ir_out  = 1'b0;
        acc_in  = 1'b0;
        acc_out = 1'b0;
        b_in    = 1'b0;
        alu_sub = 1'b0;
        alu_out = 1'b0;
        out_in  = 1'b0;

        if (!rst && !halt_q) begin
            if (ring_q[T1]) begin
                pc_out = 1'b1;
                mar_in = 1'b1;
            end else if (ring_q[T2]) begin
                pc_inc = 1'b1;
            end else if (ring_q[T3]) begin
                ram_out = 1'b1;
                ir_in   = 1'b1;
            end else if (ring_q[T4]) begin
                case (ir_ins)
                    OP_LDA, OP_ADD, OP_SUB: begin
                        ir_out = 1'b1;
                        mar_in = 1'b1;
                    end
                    OP_OUT: begin
                        acc_out = 1'b1;
                        out_in  = 1'b1;
                    end
                    OP_JMP: begin
                        ir_out  = JMP_EN;
                        pc_load = JMP_EN;
                    end
                    default: ;
                endcase
            end else if (ring_q[T5]) begin
                case (ir_ins)
                    OP_LDA: begin
                        ram_out = 1'b1;
                        acc_in  = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        ram_out = 1'b1;
                        b_in    = 1'b1;
                    end
                    default: ;
                endcase
            end else if (ring_q[T6]) begin
                case (ir_ins)
                    OP_ADD: begin
                        alu_out = 1'b1;
                        acc_in  = 1'b1;
                    end
                    OP_SUB: begin
                        alu_out = 1'b1;
                        acc_in  = 1'b1;
                        alu_sub = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign halt   = halt_q & ~rst;
    assign t_ring = rst ? 6'b000001 : ring_q;

endmodule
